// File: rtl/cgra_iobuf_if.sv
// Host/DMA and IO-PE signal bundle for cgra_iobuf.
// The level outputs exist only when CGRA_IOBUF_LEVEL_EN is defined.
interface cgra_iobuf_if #(
   parameter int SYS_DWIDTH = 32,
   parameter int DEPTH      = 16
);
`ifdef CGRA_IOBUF_LEVEL_EN
   localparam int AW = $clog2(DEPTH);
`endif

   logic                  CGRA_Ena;
   logic                  Flush;
   logic [SYS_DWIDTH-1:0] Host_WrData;
   logic                  Host_WrValid;
   logic                  Host_WrReady;
   logic [SYS_DWIDTH-1:0] Host_RdData;
   logic                  Host_RdValid;
   logic                  Host_RdReady;
   logic [SYS_DWIDTH-1:0] Data_Load;
   logic                  IOBuf_Pop;
   logic [SYS_DWIDTH-1:0] Data_Store;
   logic                  IOBuf_Push;
   logic                  Load_Empty;
   logic                  Store_Full;
   logic                  Err_Underflow;
   logic                  Err_Overflow;
`ifdef CGRA_IOBUF_LEVEL_EN
   logic [AW:0]           Load_Level;
   logic [AW:0]           Store_Level;
`endif

   modport master (
      output CGRA_Ena, Flush, Host_WrData, Host_WrValid, Host_RdReady,
             IOBuf_Pop, Data_Store, IOBuf_Push,
      input  Host_WrReady, Host_RdData, Host_RdValid, Data_Load,
             Load_Empty, Store_Full, Err_Underflow, Err_Overflow
`ifdef CGRA_IOBUF_LEVEL_EN
      , input Load_Level, Store_Level
`endif
   );

   modport slave (
      input  CGRA_Ena, Flush, Host_WrData, Host_WrValid, Host_RdReady,
             IOBuf_Pop, Data_Store, IOBuf_Push,
      output Host_WrReady, Host_RdData, Host_RdValid, Data_Load,
             Load_Empty, Store_Full, Err_Underflow, Err_Overflow
`ifdef CGRA_IOBUF_LEVEL_EN
      , output Load_Level, Store_Level
`endif
   );
endinterface

// File: rtl/cgra_iobuf.sv
// Host-facing IO buffer for one CGRA IO PE: a host->PE load FIFO and a PE->host store FIFO.
// Optional macro CGRA_IOBUF_LEVEL_EN exposes the registered FIFO counts as Load_Level/Store_Level.
module cgra_iobuf #(
   parameter  int SYS_DWIDTH = 32,
   parameter  int DEPTH      = 16,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic        Clk,
   input  logic        Reset,
   cgra_iobuf_if.slave bus
);

   localparam int NFIFO = 2;  // index 0 = load FIFO, 1 = store FIFO

   logic                  clr;
   logic [NFIFO-1:0]      wr_fire;
   logic [NFIFO-1:0]      rd_fire;
   logic [NFIFO-1:0]      full;
   logic [NFIFO-1:0]      empty;
   logic [SYS_DWIDTH-1:0] wr_data [NFIFO];
   logic [SYS_DWIDTH-1:0] head    [NFIFO];
   logic [AW:0]           count   [NFIFO];
   logic                  err_underflow_reg;
   logic                  err_overflow_reg;

   assign clr = Reset | bus.Flush;

   // Host writes into the load FIFO; the PE pops it only while the array is enabled.
   assign wr_fire[0] = bus.Host_WrValid & ~full[0];
   assign rd_fire[0] = bus.CGRA_Ena & bus.IOBuf_Pop & ~empty[0];
   assign wr_data[0] = bus.Host_WrData;

   assign wr_fire[1] = bus.CGRA_Ena & bus.IOBuf_Push & ~full[1];
   assign rd_fire[1] = ~empty[1] & bus.Host_RdReady;
   assign wr_data[1] = bus.Data_Store;

   genvar gi;
   generate
      for (gi = 0; gi < NFIFO; gi++) begin : g_fifo
         logic [SYS_DWIDTH-1:0] mem [DEPTH];
         logic [AW-1:0]         wr_ptr_reg;
         logic [AW-1:0]         rd_ptr_reg;
         logic [AW:0]           count_reg;

         always_ff @(posedge Clk) begin
            if (clr) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (wr_fire[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (rd_fire[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
               if (wr_fire[gi] && !rd_fire[gi])
                  count_reg <= count_reg + 1'b1;
               else if (!wr_fire[gi] && rd_fire[gi])
                  count_reg <= count_reg - 1'b1;
            end
         end

         // Storage is never cleared; a write racing a reset/flush is simply dropped.
         always_ff @(posedge Clk) begin
            if (wr_fire[gi] && !clr)
               mem[wr_ptr_reg] <= wr_data[gi];
         end

         assign count[gi] = count_reg;
         assign empty[gi] = (count_reg == '0);
         assign full[gi]  = (count_reg == (AW+1)'(DEPTH));
         // First-word-fall-through head, forced to zero while empty.
         assign head[gi]  = empty[gi] ? '0 : mem[rd_ptr_reg];
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (clr) begin
         err_underflow_reg <= 1'b0;
         err_overflow_reg  <= 1'b0;
      end else begin
         if (bus.CGRA_Ena && bus.IOBuf_Pop && empty[0])
            err_underflow_reg <= 1'b1;
         if (bus.CGRA_Ena && bus.IOBuf_Push && full[1])
            err_overflow_reg <= 1'b1;
      end
   end

   assign bus.Host_WrReady  = ~full[0];
   assign bus.Load_Empty    = empty[0];
   assign bus.Data_Load     = head[0];
   assign bus.Host_RdValid  = ~empty[1];
   assign bus.Store_Full    = full[1];
   assign bus.Host_RdData   = head[1];
   assign bus.Err_Underflow = err_underflow_reg;
   assign bus.Err_Overflow  = err_overflow_reg;

`ifdef CGRA_IOBUF_LEVEL_EN
   assign bus.Load_Level  = count[0];
   assign bus.Store_Level = count[1];
`endif

endmodule

// File: tb/tb_cgra_iobuf.sv
// Directed bench for cgra_iobuf with DEPTH=4; expected FIFO words are queued when driven
// and popped when the DUT presents them.
module tb_cgra_iobuf;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic Clk = 1'b0;
   logic Reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic [DW-1:0] load_q[$];
   logic [DW-1:0] store_q[$];
   logic [DW-1:0] exp_w;

   cgra_iobuf_if #(.SYS_DWIDTH(DW), .DEPTH(DEPTH)) bus ();

   cgra_iobuf #(.SYS_DWIDTH(DW), .DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vector %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
   endtask

   initial begin
      Reset = 1'b1;
      bus.CGRA_Ena = 0; bus.Flush = 0; bus.Host_WrData = '0; bus.Host_WrValid = 0;
      bus.Host_RdReady = 0; bus.IOBuf_Pop = 0; bus.Data_Store = '0; bus.IOBuf_Push = 0;
      tick(); tick();
      Reset = 1'b0;
      tick();

      // Reset state
      check("rst_load_empty", DW'(bus.Load_Empty), 1);
      check("rst_wr_ready", DW'(bus.Host_WrReady), 1);
      check("rst_rd_valid", DW'(bus.Host_RdValid), 0);
      check("rst_data_load", bus.Data_Load, 0);
      check("rst_rd_data", bus.Host_RdData, 0);
      check("rst_store_full", DW'(bus.Store_Full), 0);
      check("rst_err_under", DW'(bus.Err_Underflow), 0);
      check("rst_err_over", DW'(bus.Err_Overflow), 0);

      // Load FIFO fill/drain twice; the second pass wraps the pointers
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            bus.Host_WrData = DW'((r == 0 ? 32'hA0 : 32'hD0) + i);
            bus.Host_WrValid = 1;
            load_q.push_back(bus.Host_WrData);
            tick();
         end
         bus.Host_WrValid = 0;
         check("load_full_wr_ready", DW'(bus.Host_WrReady), 0);
         bus.CGRA_Ena = 1;
         for (int c = 0; c < 3 * DEPTH && load_q.size() > 0; c++) begin
            if (!bus.Load_Empty) begin
               exp_w = load_q.pop_front();
               check("load_data", bus.Data_Load, exp_w);
               bus.IOBuf_Pop = 1;
            end else bus.IOBuf_Pop = 0;
            tick();
         end
         bus.IOBuf_Pop = 0;
         check("load_q_drained", DW'(load_q.size()), 0);
         check("load_empty_after", DW'(bus.Load_Empty), 1);
         check("load_zero_after", bus.Data_Load, 0);
         check("no_underflow", DW'(bus.Err_Underflow), 0);
      end

      // Underflow: ignored while disabled, sticky while enabled, cleared by Flush
      bus.CGRA_Ena = 0; bus.IOBuf_Pop = 1; tick(); bus.IOBuf_Pop = 0;
      check("pop_disabled_no_err", DW'(bus.Err_Underflow), 0);
      bus.CGRA_Ena = 1; bus.IOBuf_Pop = 1; tick(); bus.IOBuf_Pop = 0;
      check("underflow_set", DW'(bus.Err_Underflow), 1);
      check("underflow_still_empty", DW'(bus.Load_Empty), 1);
      tick(); tick();
      check("underflow_sticky", DW'(bus.Err_Underflow), 1);
      bus.Flush = 1; tick(); bus.Flush = 0;
      check("underflow_flushed", DW'(bus.Err_Underflow), 0);

      // Store FIFO overflow: 5 pushes into 4 entries, the fifth is dropped
      bus.Host_RdReady = 0;
      for (int i = 0; i < 5; i++) begin
         bus.Data_Store = DW'(32'hB0 + i);
         bus.IOBuf_Push = 1;
         if (i < DEPTH) store_q.push_back(bus.Data_Store);
         tick();
      end
      bus.IOBuf_Push = 0;
      check("store_full", DW'(bus.Store_Full), 1);
      check("overflow_set", DW'(bus.Err_Overflow), 1);
`ifdef CGRA_IOBUF_LEVEL_EN
      check("store_level_full", DW'(bus.Store_Level), DEPTH);
`endif
      bus.Host_RdReady = 1;
      for (int c = 0; c < 3 * DEPTH && store_q.size() > 0; c++) begin
         if (bus.Host_RdValid) begin
            exp_w = store_q.pop_front();
            check("store_data", bus.Host_RdData, exp_w);
         end
         tick();
      end
      bus.Host_RdReady = 0;
      check("store_q_drained", DW'(store_q.size()), 0);
      check("store_b4_absent", DW'(bus.Host_RdValid), 0);
      check("store_rd_zero", bus.Host_RdData, 0);
      check("overflow_sticky", DW'(bus.Err_Overflow), 1);
      bus.Flush = 1; tick(); bus.Flush = 0;
      check("overflow_flushed", DW'(bus.Err_Overflow), 0);

      // Concurrent push and read at occupancy 2
      for (int i = 0; i < 2; i++) begin
         bus.Data_Store = DW'(32'hC0 + i); bus.IOBuf_Push = 1;
         store_q.push_back(bus.Data_Store);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         bus.Data_Store = DW'(32'hC5 + i); bus.IOBuf_Push = 1; bus.Host_RdReady = 1;
         exp_w = store_q.pop_front();
         check("concurrent_head", bus.Host_RdData, exp_w);
         store_q.push_back(bus.Data_Store);
         tick();
         check("concurrent_not_full", DW'(bus.Store_Full), 0);
      end
      bus.IOBuf_Push = 0;
      for (int c = 0; c < 8 && store_q.size() > 0; c++) begin
         if (bus.Host_RdValid) begin
            exp_w = store_q.pop_front();
            check("concurrent_tail", bus.Host_RdData, exp_w);
         end
         tick();
      end
      bus.Host_RdReady = 0;
      check("concurrent_q_drained", DW'(store_q.size()), 0);
      check("concurrent_exactly_two", DW'(bus.Host_RdValid), 0);

      // Reset mid-burst with 3 entries in each FIFO and writes still in flight
      for (int i = 0; i < 3; i++) begin
         bus.Host_WrData = DW'(32'hE0 + i); bus.Host_WrValid = 1;
         bus.Data_Store = DW'(32'hF0 + i); bus.IOBuf_Push = 1;
         tick();
      end
      Reset = 1;
      tick();
      Reset = 0; bus.Host_WrValid = 0; bus.IOBuf_Push = 0;
      check("midrst_load_empty", DW'(bus.Load_Empty), 1);
      check("midrst_rd_valid", DW'(bus.Host_RdValid), 0);
      check("midrst_data_load", bus.Data_Load, 0);
      check("midrst_wr_ready", DW'(bus.Host_WrReady), 1);
      bus.Host_WrData = 32'h11; bus.Host_WrValid = 1;
      load_q.push_back(bus.Host_WrData);
      tick();
      bus.Host_WrValid = 0;
      exp_w = load_q.pop_front();
      check("post_rst_write", bus.Data_Load, exp_w);
      check("post_rst_not_empty", DW'(bus.Load_Empty), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
